systolic_skew_feeder: RTL and testbench

- Parametrised successor to the fixed 8-lane systolic input skewer.
- Accepts one packed vector of LANES elements per handshake (typically a BRAM/im2col word) and skews it diagonally: lane k is delayed by k extra steps.
- Adds valid/ready flow control, global stall, automatic zero-drain after the last word, and synchronous flush.
- Sits between the activation BRAM reader and the row inputs of the systolic PE array.

---
 rtl/systolic_skew_feeder.sv | 178 +++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Diagonal input skewer for a systolic PE array. Each handshake accepts one
//   packed vector of LANES elements. Lane k is delayed by k extra pipeline
//   steps, so the elements reach the array rows along a diagonal wavefront.
//   After the word flagged as last, the block keeps stepping with zero data
//   until the whole diagonal has left the pipeline, then pulses done_o.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   en_i            global enable; 0 holds all state (step_o/done_o drop to 0)
//   flush_i         synchronous clear of pipeline and FSM (only when en_i=1)
//   in_valid_i/in_ready_o/in_last_i/word_i   input word handshake
//   out_ready_i     downstream can advance; 0 freezes the skew pipeline
//   skew_o          tail register of each lane (lane k at [k*DATA_W +: DATA_W])
//   out_valid_o     lane k tail holds new, real data this cycle
//   step_o          pipeline advanced on the previous edge
//   busy_o          FSM not idle
//   done_o          one-cycle pulse when the drain completes
//   word_cnt_o      accepted-word counter (only with SKEW_ACC_CNT_EN)
//
// Build option
//   SKEW_ACC_CNT_EN  adds word_cnt_o, a wrapping count of accepted words that
//                    only reset clears.
module systolic_skew_feeder #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      in_last_i,
  input  logic [LANES*DATA_W-1:0]   word_i,
  input  logic                      out_ready_i,
  output logic [LANES*DATA_W-1:0]   skew_o,
  output logic [LANES-1:0]          out_valid_o,
  output logic                      step_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef SKEW_ACC_CNT_EN
  ,
  output logic [CNT_W-1:0]          word_cnt_o
`endif
);

  localparam int unsigned DCW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  if (LANES < 1 || CNT_W < 1) begin : g_param_check
    $error("systolic_skew_feeder: LANES and CNT_W must be at least 1");
  end

  state_e           state_q, state_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic             step_q, step_d;
  logic             done_q, done_d;
  logic             accept;
  logic             adv;
  logic [LANES-1:0] tail_vld;

  assign in_ready_o = en_i & out_ready_i & ~flush_i & (state_q != ST_DRAIN);
  assign accept     = in_valid_i & in_ready_o;
  // The whole triangle steps together, so bubbles and stalls never break
  // the diagonal alignment between lanes.
  assign adv        = en_i & out_ready_i & ~flush_i &
                      (accept | (state_q == ST_DRAIN));

  // Lane k: k+1 stages of data plus valid; stage k is the visible tail.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_W-1:0] data_q [0:k];
    logic [DATA_W-1:0] data_d [0:k];
    logic [k:0]        vld_q, vld_d;

    always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (flush_i) begin
        data_d = '{default: '0};
        vld_d  = '0;
      end else if (adv) begin
        // Drain steps inject zero data marked invalid.
        data_d[0] = accept ? word_i[k*DATA_W +: DATA_W] : '0;
        vld_d[0]  = accept;
        for (int unsigned j = 1; j < k + 1; j++) begin
          data_d[j] = data_q[j-1];
          vld_d[j]  = vld_q[j-1];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q <= '{default: '0};
        vld_q  <= '0;
      end else if (en_i) begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign skew_o[k*DATA_W +: DATA_W] = data_q[k];
    assign tail_vld[k]                = vld_q[k];
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    step_d      = adv;
    done_d      = 1'b0;
    if (en_i) begin
      if (flush_i) begin
        state_d     = ST_IDLE;
        drain_cnt_d = '0;
      end else if (accept) begin
        if (!in_last_i) begin
          state_d = ST_RUN;
        end else if (LANES > 1) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DCW'(LANES - 1);
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else if (adv) begin
        // Without an accept, adv only occurs while draining.
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q == DCW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      step_q      <= step_d;
      done_q      <= done_d;
    end
  end

  assign out_valid_o = tail_vld & {LANES{step_q}};
  assign step_o      = step_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;

`ifdef SKEW_ACC_CNT_EN
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (accept) word_cnt_d = word_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) word_cnt_q <= '0;
    else         word_cnt_q <= word_cnt_d;
  end

  assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

  localparam int unsigned LANES  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned W      = LANES * DATA_W;
  localparam int unsigned VW     = W + LANES + 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en_s, flush_s, in_valid_s, in_last_s, out_ready_s;
  logic [W-1:0]     word_s;
  logic             in_ready_w;
  logic [W-1:0]     skew_w;
  logic [LANES-1:0] out_valid_w;
  logic             step_w, busy_w, done_w;
`ifdef SKEW_ACC_CNT_EN
  logic [CNT_W-1:0] word_cnt_w;
`endif

  systolic_skew_feeder #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en_s),
    .flush_i    (flush_s),
    .in_valid_i (in_valid_s),
    .in_ready_o (in_ready_w),
    .in_last_i  (in_last_s),
    .word_i     (word_s),
    .out_ready_i(out_ready_s),
    .skew_o     (skew_w),
    .out_valid_o(out_valid_w),
    .step_o     (step_w),
    .busy_o     (busy_w),
    .done_o     (done_w)
`ifdef SKEW_ACC_CNT_EN
    ,
    .word_cnt_o (word_cnt_w)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: history of pipeline steps since the last clear. Each
  // step records the word entering (or a zero bubble while draining). Lane k
  // shows the entry k steps back from the newest.
  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } ent_t;

  ent_t        hist[$];
  logic        m_busy, m_draining, m_step, m_accept;
  int          m_drain_left;
  logic [31:0] m_cnt;

  logic [VW-1:0] exp_vec, obs_vec;
  logic          exp_rdy, obs_rdy;
  int            vectors, miscompares;

  task automatic model_clear();
    hist.delete();
    m_busy = 1'b0; m_draining = 1'b0; m_step = 1'b0; m_drain_left = 0;
  endtask

  // Applies one cycle of stimulus (called at a falling edge), advances the
  // model across the rising edge and returns at the next falling edge with
  // observed/expected values ready for comparison.
  task automatic drive_cycle(input logic en, input logic flush, input logic valid,
                             input logic last, input logic [W-1:0] word,
                             input logic ordy);
    logic         adv, done;
    logic [W-1:0] es;
    logic [LANES-1:0] ev;
    en_s = en; flush_s = flush; in_valid_s = valid; in_last_s = last;
    word_s = word; out_ready_s = ordy;
    #1;
    exp_rdy  = en & ordy & ~flush & ~m_draining;
    obs_rdy  = in_ready_w;
    m_accept = valid & exp_rdy;
    adv      = en & ordy & ~flush & (m_accept | m_draining);
    @(posedge clk);
    done = 1'b0;
    if (en && flush) begin
      model_clear();
    end else if (adv) begin
      hist.push_back({m_accept, m_accept ? word : {W{1'b0}}});
      if (hist.size() > LANES) void'(hist.pop_front());
      if (m_accept) begin
        if (last) begin
          if (LANES > 1) begin
            m_draining = 1'b1; m_drain_left = LANES - 1; m_busy = 1'b1;
          end else begin
            m_busy = 1'b0; done = 1'b1;
          end
        end else begin
          m_busy = 1'b1;
        end
      end else begin
        m_drain_left--;
        if (m_drain_left == 0) begin
          m_draining = 1'b0; m_busy = 1'b0; done = 1'b1;
        end
      end
    end
    if (m_accept) m_cnt = m_cnt + 1;
    m_step = adv;
    @(negedge clk);
    es = '0; ev = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      int idx = int'(hist.size()) - 1 - k;
      if (idx >= 0) begin
        es[k*DATA_W +: DATA_W] = hist[idx].d[k*DATA_W +: DATA_W];
        ev[k] = hist[idx].v & m_step;
      end
    end
    exp_vec = {es, ev, m_step, m_busy, done};
    obs_vec = {skew_w, out_valid_w, step_w, busy_w, done_w};
  endtask

  function automatic logic [W-1:0] splat(input logic [DATA_W-1:0] b);
    return {LANES{b}};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en_s = 1'b1; flush_s = 1'b0; in_valid_s = 1'b0; in_last_s = 1'b0;
    word_s = '0; out_ready_s = 1'b1;
    model_clear(); m_cnt = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({skew_w, out_valid_w, step_w, busy_w, done_w} !== {VW{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_hold: got %h, want 0", {skew_w, out_valid_w, step_w, busy_w, done_w});
    end
    rst_n = 1'b1;
    drive_cycle(1, 0, 0, 0, '0, 1);
    vectors++;
    if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
      miscompares++;
      $display("FAIL reset_idle: got %h rdy=%b, want %h rdy=%b", obs_vec, obs_rdy, exp_vec, exp_rdy);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 0, 1, 0, {$urandom, $urandom}, 1);
      vectors++;
      if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL async_rst_run c%0d: got %h rdy=%b, want %h rdy=%b", i, obs_vec, obs_rdy, exp_vec, exp_rdy);
      end
    end
`ifdef SKEW_ACC_CNT_EN
    vectors++;
    if (word_cnt_w !== 32'd5) begin
      miscompares++;
      $display("FAIL word_cnt_before_reset: got %0d, want 5", word_cnt_w);
    end
`endif
    in_valid_s = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({skew_w, out_valid_w, step_w, busy_w, done_w} !== {VW{1'b0}}) begin
      miscompares++;
      $display("FAIL async_rst_clear: got %h, want 0", {skew_w, out_valid_w, step_w, busy_w, done_w});
    end
`ifdef SKEW_ACC_CNT_EN
    vectors++;
    if (word_cnt_w !== '0) begin
      miscompares++;
      $display("FAIL word_cnt_reset: got %0d, want 0", word_cnt_w);
    end
`endif
    model_clear(); m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    logic [W-1:0] w;
    w = 64'h0807060504030201;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, 0, (i == 0), (i == 0), w, 1);
      vectors++;
      if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL single c%0d: got %h rdy=%b, want %h rdy=%b", i, obs_vec, obs_rdy, exp_vec, exp_rdy);
      end
      if (i < 8) begin
        vectors++;
        if (skew_w[i*DATA_W +: DATA_W] !== 8'(i + 1) || out_valid_w !== 8'(1 << i)) begin
          miscompares++;
          $display("FAIL single_diag lane%0d: got %h ov=%b, want %h ov=%b", i,
                   skew_w[i*DATA_W +: DATA_W], out_valid_w, 8'(i + 1), 8'(1 << i));
        end
      end
      if (i == 7 || i == 8) begin
        vectors++;
        if (done_w !== (i == 7) || busy_w !== 1'b0) begin
          miscompares++;
          $display("FAIL single_done c%0d: got done=%b busy=%b, want done=%b busy=0", i, done_w, busy_w, i == 7);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 13; i++) begin
      drive_cycle(1, 0, (i < 4), (i == 3), splat(8'((i + 1) * 8'h11)), 1);
      vectors++;
      if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL b2b c%0d: got %h rdy=%b, want %h rdy=%b", i, obs_vec, obs_rdy, exp_vec, exp_rdy);
      end
      if (i >= 3 && i <= 6) begin
        vectors++;
        if (skew_w[3*DATA_W +: DATA_W] !== 8'((i - 2) * 8'h11)) begin
          miscompares++;
          $display("FAIL b2b_lane3 c%0d: got %h, want %h", i, skew_w[3*DATA_W +: DATA_W], 8'((i - 2) * 8'h11));
        end
      end
      if (i >= 4 && i <= 10) begin
        vectors++;
        if (obs_rdy !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_drain_ready c%0d: got %b, want 0", i, obs_rdy);
        end
      end
      if (i == 10) begin
        vectors++;
        if (done_w !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_done: got %b, want 1", done_w);
        end
      end
    end
  endtask

  task automatic test_stall();
    int idx;
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      logic ordy;
      ordy = !(i >= 2 && i <= 4);
      drive_cycle(1, 0, (idx < 6), (idx == 5), {$urandom, $urandom}, ordy);
      if (m_accept) idx++;
      vectors++;
      if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL stall c%0d: got %h rdy=%b, want %h rdy=%b", i, obs_vec, obs_rdy, exp_vec, exp_rdy);
      end
      if (i >= 2 && i <= 4) begin
        vectors++;
        if (obs_rdy !== 1'b0 || step_w !== 1'b0 || out_valid_w !== '0) begin
          miscompares++;
          $display("FAIL stall_hold c%0d: got rdy=%b step=%b ov=%b, want 0 0 0", i, obs_rdy, step_w, out_valid_w);
        end
      end
    end
  endtask

  task automatic test_bubble();
    int idx;
    idx = 0;
    for (int i = 0; i < 18; i++) begin
      logic v;
      v = (idx < 5) && !(i == 2 || i == 3);
      drive_cycle(1, 0, v, (idx == 4), {$urandom, $urandom}, 1);
      if (m_accept) idx++;
      vectors++;
      if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL bubble c%0d: got %h rdy=%b, want %h rdy=%b", i, obs_vec, obs_rdy, exp_vec, exp_rdy);
      end
      if (i == 2 || i == 3) begin
        vectors++;
        if (out_valid_w !== '0 || step_w !== 1'b0) begin
          miscompares++;
          $display("FAIL bubble_idle c%0d: got ov=%b step=%b, want 0 0", i, out_valid_w, step_w);
        end
      end
    end
  endtask

  task automatic test_flush_mid_drain();
    // Accept a last word (drain count 7), three drain steps bring it to 4.
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 0, (i == 0), 1, {$urandom, $urandom}, 1);
      vectors++;
      if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL flush_pre c%0d: got %h rdy=%b, want %h rdy=%b", i, obs_vec, obs_rdy, exp_vec, exp_rdy);
      end
    end
    drive_cycle(1, 1, 1, 0, {$urandom, $urandom}, 1);
    vectors++;
    if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
      miscompares++;
      $display("FAIL flush_cycle: got %h rdy=%b, want %h rdy=%b", obs_vec, obs_rdy, exp_vec, exp_rdy);
    end
    vectors++;
    if (skew_w !== '0 || out_valid_w !== '0 || busy_w !== 1'b0 || done_w !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: got skew=%h ov=%b busy=%b done=%b, want all 0", skew_w, out_valid_w, busy_w, done_w);
    end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, 0, (i == 0), 1, {$urandom, $urandom}, 1);
      vectors++;
      if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL flush_post c%0d: got %h rdy=%b, want %h rdy=%b", i, obs_vec, obs_rdy, exp_vec, exp_rdy);
      end
      if (i == 0) begin
        vectors++;
        if (obs_rdy !== 1'b1 || busy_w !== 1'b1) begin
          miscompares++;
          $display("FAIL flush_reaccept: got rdy=%b busy=%b, want 1 1", obs_rdy, busy_w);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      logic en, fl, v, l, o;
      en = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 9) == 0);
      o  = ($urandom_range(0, 9) < 8);
      drive_cycle(en, fl, v, l, {$urandom, $urandom}, o);
      vectors++;
      if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL random c%0d: got %h rdy=%b, want %h rdy=%b", i, obs_vec, obs_rdy, exp_vec, exp_rdy);
      end
`ifdef SKEW_ACC_CNT_EN
      vectors++;
      if (word_cnt_w !== m_cnt) begin
        miscompares++;
        $display("FAIL random_word_cnt c%0d: got %0d, want %0d", i, word_cnt_w, m_cnt);
      end
`endif
    end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, 0, 0, 0, '0, 1);
      vectors++;
      if (obs_vec !== exp_vec || obs_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL random_tail c%0d: got %h rdy=%b, want %h rdy=%b", i, obs_vec, obs_rdy, exp_vec, exp_rdy);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    @(negedge clk);
    test_reset();
    test_async_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_bubble();
    test_flush_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
